// File: rtl/core_pkg.sv
// Core-wide sizing shared by the execution and writeback blocks.
package core_pkg;
    localparam int XLEN   = 32;
    localparam int PREG_W = 6;
    typedef logic [PREG_W-1:0] preg_tag_t;
endpackage

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs drained onto two PRF write ports
// using a rotating-priority scan that starts at rr_ptr.
module wb_arbiter #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int N_SRC = 4,
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [N_SRC-1:0]                  src_valid,
    input  logic [N_SRC*core_pkg::PREG_W-1:0] src_tag,
    input  logic [N_SRC*XLEN-1:0]             src_data,
    output logic [N_SRC-1:0]                  src_ready,
    output logic                              wen0,
    output logic [core_pkg::PREG_W-1:0]       wtag0,
    output logic [XLEN-1:0]                   wdata0,
    output logic                              wen1,
    output logic [core_pkg::PREG_W-1:0]       wtag1,
    output logic [XLEN-1:0]                   wdata1
);
    localparam int TW = core_pkg::PREG_W;
    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    core_pkg::preg_tag_t tag_mem  [N_SRC][DEPTH];
    logic [XLEN-1:0]     data_mem [N_SRC][DEPTH];
    logic [AW-1:0]       rd_ptr   [N_SRC];
    logic [AW-1:0]       wr_ptr   [N_SRC];
    logic [CW-1:0]       count    [N_SRC];
    logic [PW-1:0]       rr_ptr;

    core_pkg::preg_tag_t head_tag  [N_SRC];
    logic [XLEN-1:0]     head_data [N_SRC];
    logic [N_SRC-1:0]    nonempty;
    logic [N_SRC-1:0]    push;
    logic [N_SRC-1:0]    pop;

    logic                gnt0;
    logic                gnt1;
    logic                found0;
    logic                found1;
    logic [PW-1:0]       sel0;
    logic [PW-1:0]       sel1;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [PW-1:0] src_inc(input logic [PW-1:0] s);
        return (s == PW'(N_SRC - 1)) ? '0 : s + PW'(1);
    endfunction

    // Handshake: a source transfers on a rising edge where src_valid[i] && src_ready[i];
    // src_ready depends only on the registered count (plus reset/flush), never on grants.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            nonempty[i]  = (count[i] != '0);
            src_ready[i] = (reset || (count[i] < CW'(DEPTH))) && !flush;
            head_tag[i]  = tag_mem[i][rd_ptr[i]];
            head_data[i] = data_mem[i][rd_ptr[i]];
            push[i]      = src_valid[i] && src_ready[i];
        end
    end

    // First two non-empty heads in rotation order from rr_ptr; port 1 is
    // suppressed when it would write the same tag as port 0 in this cycle.
    always_comb begin
        int            idx;
        logic [PW-1:0] cur;
        idx    = 0;
        cur    = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        sel0   = '0;
        sel1   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % N_SRC;
            cur = PW'(idx);
            if (nonempty[cur]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    sel0   = cur;
                end else if (!found1) begin
                    found1 = 1'b1;
                    sel1   = cur;
                end
            end
        end
        gnt0 = found0 && !reset && !flush;
        gnt1 = gnt0 && found1 && (head_tag[sel1] != head_tag[sel0]);
        for (int i = 0; i < N_SRC; i++) begin
            pop[i] = (gnt0 && (sel0 == PW'(i))) || (gnt1 && (sel1 == PW'(i)));
        end
    end

    always_comb begin
        wen0   = gnt0;
        wtag0  = gnt0 ? head_tag[sel0]  : '0;
        wdata0 = gnt0 ? head_data[sel0] : '0;
        wen1   = gnt1;
        wtag1  = gnt1 ? head_tag[sel1]  : '0;
        wdata1 = gnt1 ? head_data[sel1] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            if (gnt1) begin
                rr_ptr <= src_inc(sel1);
            end else if (gnt0) begin
                rr_ptr <= src_inc(sel0);
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]]  <= src_tag[i*TW +: TW];
                data_mem[i][wr_ptr[i]] <= src_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default core_pkg::XLEN, datapath width.
REQ-002 Parameter N_SRC, default 4, number of functional-unit result sources (0=ALU0, 1=ALU1, 2=MUL, 3=LSU).
REQ-003 Parameter DEPTH, default 2, entries per source buffer.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 flush  input  1  discard all buffered results.
REQ-007 src_valid  input  N_SRC  per-source result valid.
REQ-008 src_tag  input  N_SRC x core_pkg::preg_tag_t  destination physical tag per source.
REQ-009 src_data  input  N_SRC x XLEN  result data per source.
REQ-010 src_ready  output  N_SRC  per-source buffer can accept.
REQ-011 wen0 / wtag0 / wdata0  output  1 / preg_tag_t / XLEN  PRF write port 0 (priority port).
REQ-012 wen1 / wtag1 / wdata1  output  1 / preg_tag_t / XLEN  PRF write port 1.

Function
REQ-013 Each source owns a DEPTH-entry FIFO of {tag, data}; transfer occurs when src_valid[i] && src_ready[i] at a rising edge.
REQ-014 src_ready[i] = (count[i] < DEPTH) && !flush; derived from registered count only, no dependency on same-cycle grant.
REQ-015 Write outputs SHALL be combinational from registered FIFO heads and rr_ptr only; no combinational path from src_* inputs to wen*/wtag*/wdata*.
REQ-016 Latency: result accepted at edge ending cycle N appears on a write port no earlier than cycle N+1.
REQ-017 Selection: scan sources starting at rr_ptr, ascending mod N_SRC; first non-empty head -> port 0; next non-empty head from a different source -> port 1.
REQ-018 At most one entry per source granted per cycle.
REQ-019 If port-1 candidate tag equals port-0 tag, wen1 = 0 that cycle and that entry stays buffered.
REQ-020 Granted heads pop at the rising edge of the cycle they are driven; push and pop on the same FIFO in one cycle are both honoured, count unchanged.
REQ-021 rr_ptr update: if any grant, rr_ptr <= (last granted source index + 1) mod N_SRC; if no grant, rr_ptr holds.
REQ-022 When wenX = 0, wtagX and wdataX SHALL be driven 0.
REQ-023 FIFO pointers wrap modulo DEPTH; order within a source is strictly preserved.
REQ-024 flush = 1: all counts <= 0 at the edge, pushes that cycle dropped, wen0/wen1 forced 0 in the flush cycle, rr_ptr unchanged.
REQ-025 No data loss: every accepted result is written exactly once unless flushed or reset.

Reset
REQ-026 reset = 1 at a rising edge: all counts and pointers <= 0, rr_ptr <= 0; takes priority over flush and pushes.
REQ-027 While reset is high and in the cycle after: src_ready = all ones (when flush = 0), wen0 = wen1 = 0, wtag*/wdata* = 0.
REQ-028 Reset asserted mid-operation discards all buffered entries; none appear on write ports afterward.

Verification
REQ-029 Single: after reset, src 2 pushes tag 5, data 0xAB in cycle 1 -> cycle 2: wen0 = 1, wtag0 = 5, wdata0 = 0xAB, wen1 = 0; cycle 3: both wen = 0.
REQ-030 Fairness: all 4 sources push one entry in the same cycle, rr_ptr = 0 -> next cycle ports = src0/src1, rr_ptr -> 2; following cycle = src2/src3, rr_ptr -> 0.
REQ-031 Tag conflict: src0 tag 7 data 1, src1 tag 7 data 2 pushed together -> port 0 writes data 1, wen1 = 0; next cycle port 0 writes tag 7 data 2.
REQ-032 Backpressure: src1 pushes 3 consecutive cycles while src0 holds higher priority each cycle -> src_ready[1] = 0 with count = 2, no entry lost, src1 writes emerge in push order.
REQ-033 Flush: 3 entries buffered, flush pulsed one cycle with a concurrent push -> in the flush cycle wen0 = wen1 = 0; next cycle all counts = 0, src_ready = all ones, no writes ever emerge for those entries.
REQ-034 Reset mid-stream: reset asserted with 4 entries buffered -> next cycle wen0 = wen1 = 0, rr_ptr = 0, buffered entries never written.
